// File: rtl/sar_search_8bit_pkg.sv
// Shared definitions for comparator-driven successive-approximation search.
// State encodings and flag helpers reused by any comparator consumer.
package sar_search_8bit_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        SEARCH = S_SEARCH,
        VERIFY = S_VERIFY
    } sarState_t;

    // A well-behaved magnitude comparator asserts exactly one of its three flags.
    function automatic logic isOneHot(input logic lt, input logic eq, input logic gt);
        return ({lt, eq, gt} == 3'b100) || ({lt, eq, gt} == 3'b010) ||
               ({lt, eq, gt} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search_8bit.sv
// Successive-approximation search controller: drives a trial value into an
// external comparator and bisects MSB-first until the hidden target is found.
module sar_search_8bit
    import sar_search_8bit_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pLessThanQ,
    input  logic             pEqualToQ,
    input  logic             pGreaterThanQ,
    output logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             error
);

    localparam int                IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
    localparam logic [WIDTH-1:0]  ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0]  MSB     = ONE << (WIDTH - 1);

    sarState_t        state, stateNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic [WIDTH-1:0] guessNext, resultNext, decided;
    logic             doneNext, foundNext, errorNext, flagsOk;

    assign flagsOk = isOneHot(pLessThanQ, pEqualToQ, pGreaterThanQ);
    // Only the bit under test can change, so no carry or borrow ever ripples.
    assign decided = pGreaterThanQ ? (guess & ~(ONE << idx)) : guess;
    assign busy    = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            guess  <= '0;
            result <= '0;
            idx    <= IDX_MSB;
            done   <= 1'b0;
            found  <= 1'b0;
            error  <= 1'b0;
        end else begin
            state  <= stateNext;
            guess  <= guessNext;
            result <= resultNext;
            idx    <= idxNext;
            done   <= doneNext;
            found  <= foundNext;
            error  <= errorNext;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        stateNext  = state;
        guessNext  = guess;
        resultNext = result;
        idxNext    = idx;
        doneNext   = 1'b0;
        foundNext  = found;
        errorNext  = error;

        case (state)
            IDLE: begin
                if (start) begin
                    guessNext = MSB;
                    idxNext   = IDX_MSB;
                    foundNext = 1'b0;
                    errorNext = 1'b0;
                    stateNext = SEARCH;
                end
            end

            SEARCH: begin
                if (!flagsOk) begin
                    errorNext  = 1'b1;
                    foundNext  = 1'b0;
                    resultNext = guess;
                    doneNext   = 1'b1;
                    stateNext  = IDLE;
                end else if (EARLY_EXIT && pEqualToQ) begin
                    resultNext = guess;
                    foundNext  = 1'b1;
                    doneNext   = 1'b1;
                    stateNext  = IDLE;
                end else if (idx != '0) begin
                    guessNext = decided | (ONE << (idx - IDX_ONE));
                    idxNext   = idx - IDX_ONE;
                end else begin
                    guessNext = decided;
                    stateNext = VERIFY;
                end
            end

            VERIFY: begin
                errorNext  = !flagsOk;
                foundNext  = flagsOk && pEqualToQ;
                resultNext = guess;
                doneNext   = 1'b1;
                stateNext  = IDLE;
            end

            default: stateNext = IDLE;
        endcase
    end

endmodule
